// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI decode stage.
// Condition codes, instruction classes, ALU ops and decoded bundles.
package arm7tdmi_pkg;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC,
    COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT,
    COND_GT, COND_LE, COND_AL, COND_NV
  } condition_t;

  typedef enum logic [3:0] {
    INSTR_DATA_PROC,
    INSTR_MULTIPLY,
    INSTR_MULTIPLY_LONG,
    INSTR_SINGLE_SWAP,
    INSTR_BX,
    INSTR_HALFWORD,
    INSTR_PSR,
    INSTR_UNDEFINED,
    INSTR_SINGLE_XFER,
    INSTR_BLOCK_XFER,
    INSTR_BRANCH,
    INSTR_CP_DATA_XFER,
    INSTR_CP_DATA_OP,
    INSTR_CP_REG_XFER,
    INSTR_SWI,
    INSTR_THUMB
  } instr_type_t;

  typedef enum logic [3:0] {
    ALU_AND, ALU_EOR, ALU_SUB, ALU_RSB,
    ALU_ADD, ALU_ADC, ALU_SBC, ALU_RSC,
    ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN,
    ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN
  } alu_op_t;

  typedef enum logic [1:0] {
    SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR
  } shift_type_t;

  typedef enum logic [4:0] {
    THUMB_NONE,
    THUMB_SHIFT_IMM,
    THUMB_ADD_SUB,
    THUMB_MOV_CMP_IMM,
    THUMB_ALU,
    THUMB_HI_BX,
    THUMB_PC_LOAD,
    THUMB_LS_REG,
    THUMB_LS_SIGN,
    THUMB_LS_IMM,
    THUMB_LS_HALF,
    THUMB_SP_LS,
    THUMB_LOAD_ADDR,
    THUMB_SP_ADJ,
    THUMB_PUSH_POP,
    THUMB_LS_MULTI,
    THUMB_COND_BR,
    THUMB_SWI,
    THUMB_UNCOND_BR,
    THUMB_LONG_BL
  } thumb_instr_t;

  typedef struct packed {
    thumb_instr_t ttype;
    logic [2:0]   rd;
    logic [2:0]   rs;
    logic [2:0]   rn;
    logic [7:0]   imm8;
    logic [4:0]   imm5;
    logic [10:0]  offset11;
    logic [7:0]   offset8;
  } thumb_fields_t;

  typedef struct packed {
    condition_t    condition;
    instr_type_t   instr_type;
    alu_op_t       alu_op;
    logic [3:0]    rd;
    logic [3:0]    rn;
    logic [3:0]    rm;
    logic [11:0]   immediate;
    logic          imm_en;
    logic          set_flags;
    shift_type_t   shift_type;
    logic [4:0]    shift_amount;
    logic          shift_reg;
    logic [3:0]    shift_rs;
    logic          is_memory;
    logic          mem_load;
    logic          mem_byte;
    logic          mem_pre;
    logic          mem_up;
    logic          mem_writeback;
    logic          is_branch;
    logic [23:0]   branch_offset;
    logic          branch_link;
    logic          psr_to_reg;
    logic          psr_spsr;
    logic          psr_immediate;
    logic          cp_op;
    logic [3:0]    cp_num;
    logic [3:0]    cp_rd;
    logic [3:0]    cp_rn;
    logic [3:0]    cp_opcode1;
    logic [2:0]    cp_opcode2;
    logic          cp_load;
    thumb_fields_t thumb;
    logic [31:0]   pc;
  } decode_t;

  // First match wins; order resolves the overlapping encodings.
  function automatic instr_type_t arm_class(input logic [27:4] w);
    instr_type_t t;
    if (w == 24'h12FFF1)
      t = INSTR_BX;
    else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00
             && w[11:4] == 8'h09)
      t = INSTR_SINGLE_SWAP;
    else if (w[27:22] == 6'b000000 && w[7:4] == 4'b1001)
      t = INSTR_MULTIPLY;
    else if (w[27:23] == 5'b00001 && w[7:4] == 4'b1001)
      t = INSTR_MULTIPLY_LONG;
    else if (w[27:25] == 3'b000 && w[7] && w[4])
      t = INSTR_HALFWORD;
    else if (w[27:26] == 2'b00 && w[24:23] == 2'b10 && !w[20])
      t = INSTR_PSR;
    else if (w[27:26] == 2'b00)
      t = INSTR_DATA_PROC;
    else if (w[27:25] == 3'b011 && w[4])
      t = INSTR_UNDEFINED;
    else if (w[27:26] == 2'b01)
      t = INSTR_SINGLE_XFER;
    else if (w[27:25] == 3'b100)
      t = INSTR_BLOCK_XFER;
    else if (w[27:25] == 3'b101)
      t = INSTR_BRANCH;
    else if (w[27:25] == 3'b110)
      t = INSTR_CP_DATA_XFER;
    else if (w[27:24] == 4'b1110)
      t = w[4] ? INSTR_CP_REG_XFER : INSTR_CP_DATA_OP;
    else
      t = INSTR_SWI;
    return t;
  endfunction

endpackage

// File: rtl/arm7tdmi_thumb_field_decode.sv
// Thumb halfword format select and field extraction.
// Purely combinational; unused fields stay zero.
module arm7tdmi_thumb_field_decode
  import arm7tdmi_pkg::*;
(
  input  logic [15:0]   hw,
  output thumb_fields_t tf
);

  logic [7:0]   op;
  thumb_instr_t ty;

  assign op = hw[15:8];

  always_comb begin
    ty = THUMB_NONE;
    if (op[7:3] == 5'b00011)       ty = THUMB_ADD_SUB;
    else if (op[7:5] == 3'b000)    ty = THUMB_SHIFT_IMM;
    else if (op[7:5] == 3'b001)    ty = THUMB_MOV_CMP_IMM;
    else if (op[7:2] == 6'b010000) ty = THUMB_ALU;
    else if (op[7:2] == 6'b010001) ty = THUMB_HI_BX;
    else if (op[7:3] == 5'b01001)  ty = THUMB_PC_LOAD;
    else if (op[7:4] == 4'b0101)
      ty = op[1] ? THUMB_LS_SIGN : THUMB_LS_REG;
    else if (op[7:5] == 3'b011)    ty = THUMB_LS_IMM;
    else if (op[7:4] == 4'b1000)   ty = THUMB_LS_HALF;
    else if (op[7:4] == 4'b1001)   ty = THUMB_SP_LS;
    else if (op[7:4] == 4'b1010)   ty = THUMB_LOAD_ADDR;
    else if (op == 8'hB0)          ty = THUMB_SP_ADJ;
    else if (op[7:4] == 4'b1011 && op[2:1] == 2'b10)
      ty = THUMB_PUSH_POP;
    else if (op[7:4] == 4'b1100)   ty = THUMB_LS_MULTI;
    else if (op == 8'hDF)          ty = THUMB_SWI;
    else if (op[7:4] == 4'b1101)   ty = THUMB_COND_BR;
    else if (op[7:3] == 5'b11100)  ty = THUMB_UNCOND_BR;
    else if (op[7:4] == 4'b1111)   ty = THUMB_LONG_BL;
  end

  always_comb begin
    tf = '0;
    tf.ttype = ty;
    unique case (ty)
      THUMB_SHIFT_IMM, THUMB_LS_IMM, THUMB_LS_HALF: begin
        tf.rd   = hw[2:0];
        tf.rs   = hw[5:3];
        tf.imm5 = hw[10:6];
      end
      THUMB_ADD_SUB, THUMB_LS_REG, THUMB_LS_SIGN: begin
        tf.rd = hw[2:0];
        tf.rs = hw[5:3];
        tf.rn = hw[8:6];
      end
      THUMB_ALU, THUMB_HI_BX: begin
        tf.rd = hw[2:0];
        tf.rs = hw[5:3];
      end
      THUMB_MOV_CMP_IMM, THUMB_PC_LOAD, THUMB_SP_LS,
      THUMB_LOAD_ADDR, THUMB_LS_MULTI: begin
        tf.rd   = hw[10:8];
        tf.imm8 = hw[7:0];
      end
      THUMB_SP_ADJ, THUMB_PUSH_POP, THUMB_SWI:
        tf.imm8 = hw[7:0];
      THUMB_COND_BR:
        tf.offset8 = hw[7:0];
      THUMB_UNCOND_BR, THUMB_LONG_BL:
        tf.offset11 = hw[10:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/arm7tdmi_instr_decode.sv
// ARM7TDMI decode stage: classifies ARM/Thumb words and
// registers the extracted operand fields for execute.
module arm7tdmi_instr_decode
  import arm7tdmi_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  instruction,
  input  logic [31:0]  pc_in,
  input  logic         instr_valid,
  input  logic         stall,
  input  logic         flush,
  input  logic         thumb_mode,
  output condition_t   condition,
  output instr_type_t  instr_type,
  output alu_op_t      alu_op,
  output logic [3:0]   rd,
  output logic [3:0]   rn,
  output logic [3:0]   rm,
  output logic [11:0]  immediate,
  output logic         imm_en,
  output logic         set_flags,
  output logic [1:0]   shift_type,
  output logic [4:0]   shift_amount,
  output logic         shift_reg,
  output logic [3:0]   shift_rs,
  output logic         is_memory,
  output logic         mem_load,
  output logic         mem_byte,
  output logic         mem_pre,
  output logic         mem_up,
  output logic         mem_writeback,
  output logic         is_branch,
  output logic [23:0]  branch_offset,
  output logic         branch_link,
  output logic         psr_to_reg,
  output logic         psr_spsr,
  output logic         psr_immediate,
  output logic         cp_op,
  output logic [3:0]   cp_num,
  output logic [3:0]   cp_rd,
  output logic [3:0]   cp_rn,
  output logic [3:0]   cp_opcode1,
  output logic [2:0]   cp_opcode2,
  output logic         cp_load,
  output thumb_instr_t thumb_instr_type,
  output logic [2:0]   thumb_rd,
  output logic [2:0]   thumb_rs,
  output logic [2:0]   thumb_rn,
  output logic [7:0]   thumb_imm8,
  output logic [4:0]   thumb_imm5,
  output logic [10:0]  thumb_offset11,
  output logic [7:0]   thumb_offset8,
  output logic [31:0]  pc_out,
  output logic         decode_valid
);

  logic [31:0]   ir;
  instr_type_t   cls;
  thumb_fields_t tf;
  decode_t       dec;
  decode_t       dec_d, dec_q;
  logic          valid_d, valid_q;

  assign ir  = instruction;
  assign cls = arm_class(ir[27:4]);

  arm7tdmi_thumb_field_decode u_thumb (
    .hw (instruction[15:0]),
    .tf (tf)
  );

  always_comb begin
    dec = '0;
    dec.pc = pc_in;
    if (thumb_mode) begin
      dec.condition  = COND_AL;
      dec.instr_type = INSTR_THUMB;
      dec.thumb      = tf;
    end else begin
      dec.condition  = condition_t'(ir[31:28]);
      dec.instr_type = cls;
      unique case (cls)
        INSTR_DATA_PROC: begin
          dec.alu_op    = alu_op_t'(ir[24:21]);
          dec.rd        = ir[15:12];
          dec.rn        = ir[19:16];
          dec.set_flags = ir[20];
          dec.imm_en    = ir[25];
          if (ir[25]) begin
            dec.immediate = ir[11:0];
          end else begin
            dec.rm         = ir[3:0];
            dec.shift_type = shift_type_t'(ir[6:5]);
            dec.shift_reg  = ir[4];
            if (ir[4]) dec.shift_rs = ir[11:8];
            else dec.shift_amount = ir[11:7];
          end
        end
        INSTR_MULTIPLY, INSTR_MULTIPLY_LONG: begin
          dec.rd        = ir[15:12];
          dec.rn        = ir[19:16];
          dec.rm        = ir[3:0];
          dec.shift_rs  = ir[11:8];
          dec.set_flags = ir[20];
        end
        INSTR_SINGLE_SWAP: begin
          dec.rd        = ir[15:12];
          dec.rn        = ir[19:16];
          dec.rm        = ir[3:0];
          dec.is_memory = 1'b1;
          dec.mem_load  = 1'b1;
          dec.mem_pre   = 1'b1;
          dec.mem_up    = 1'b1;
          dec.mem_byte  = ir[22];
        end
        INSTR_HALFWORD, INSTR_SINGLE_XFER,
        INSTR_BLOCK_XFER: begin
          dec.is_memory     = 1'b1;
          dec.rn            = ir[19:16];
          dec.mem_pre       = ir[24];
          dec.mem_up        = ir[23];
          dec.mem_byte      = ir[22];
          dec.mem_writeback = ir[21];
          dec.mem_load      = ir[20];
          // Offset form: halfword I is [22], single uses inverted [25].
          if (cls == INSTR_HALFWORD) begin
            dec.rd     = ir[15:12];
            dec.imm_en = ir[22];
            if (ir[22]) dec.immediate = {4'h0, ir[11:8], ir[3:0]};
            else dec.rm = ir[3:0];
          end else if (cls == INSTR_SINGLE_XFER) begin
            dec.rd     = ir[15:12];
            dec.imm_en = !ir[25];
            if (!ir[25]) begin
              dec.immediate = ir[11:0];
            end else begin
              dec.rm           = ir[3:0];
              dec.shift_type   = shift_type_t'(ir[6:5]);
              dec.shift_amount = ir[11:7];
            end
          end
        end
        INSTR_PSR: begin
          dec.psr_spsr = ir[22];
          if (!ir[21]) begin
            dec.psr_to_reg = 1'b1;
            dec.rd         = ir[15:12];
          end else begin
            dec.psr_immediate = ir[25];
            dec.imm_en        = ir[25];
            dec.rn            = ir[19:16];
            if (ir[25]) dec.immediate = ir[11:0];
            else dec.rm = ir[3:0];
          end
        end
        INSTR_BX: begin
          dec.is_branch = 1'b1;
          dec.rm        = ir[3:0];
        end
        INSTR_BRANCH: begin
          dec.is_branch     = 1'b1;
          dec.branch_offset = ir[23:0];
          dec.branch_link   = ir[24];
        end
        INSTR_CP_DATA_XFER: begin
          dec.cp_op         = 1'b1;
          dec.is_memory     = 1'b1;
          dec.cp_num        = ir[11:8];
          dec.cp_rd         = ir[15:12];
          dec.rn            = ir[19:16];
          dec.mem_pre       = ir[24];
          dec.mem_up        = ir[23];
          dec.mem_writeback = ir[21];
          dec.mem_load      = ir[20];
          dec.cp_load       = ir[20];
          dec.imm_en        = 1'b1;
          dec.immediate     = {4'h0, ir[7:0]};
        end
        INSTR_CP_DATA_OP: begin
          dec.cp_op      = 1'b1;
          dec.cp_num     = ir[11:8];
          dec.cp_rd      = ir[15:12];
          dec.cp_rn      = ir[19:16];
          dec.cp_opcode1 = ir[23:20];
          dec.cp_opcode2 = ir[7:5];
          dec.rm         = ir[3:0];
        end
        INSTR_CP_REG_XFER: begin
          dec.cp_op      = 1'b1;
          dec.cp_num     = ir[11:8];
          dec.rd         = ir[15:12];
          dec.cp_rn      = ir[19:16];
          dec.cp_opcode1 = {1'b0, ir[23:21]};
          dec.cp_opcode2 = ir[7:5];
          dec.cp_load    = ir[20];
          dec.rm         = ir[3:0];
        end
        default: ;
      endcase
    end
  end

  // Flush only kills validity; stall freezes everything.
  always_comb begin
    dec_d   = dec_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      dec_d   = dec;
      valid_d = instr_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  assign condition        = dec_q.condition;
  assign instr_type       = dec_q.instr_type;
  assign alu_op           = dec_q.alu_op;
  assign rd               = dec_q.rd;
  assign rn               = dec_q.rn;
  assign rm               = dec_q.rm;
  assign immediate        = dec_q.immediate;
  assign imm_en           = dec_q.imm_en;
  assign set_flags        = dec_q.set_flags;
  assign shift_type       = dec_q.shift_type;
  assign shift_amount     = dec_q.shift_amount;
  assign shift_reg        = dec_q.shift_reg;
  assign shift_rs         = dec_q.shift_rs;
  assign is_memory        = dec_q.is_memory;
  assign mem_load         = dec_q.mem_load;
  assign mem_byte         = dec_q.mem_byte;
  assign mem_pre          = dec_q.mem_pre;
  assign mem_up           = dec_q.mem_up;
  assign mem_writeback    = dec_q.mem_writeback;
  assign is_branch        = dec_q.is_branch;
  assign branch_offset    = dec_q.branch_offset;
  assign branch_link      = dec_q.branch_link;
  assign psr_to_reg       = dec_q.psr_to_reg;
  assign psr_spsr         = dec_q.psr_spsr;
  assign psr_immediate    = dec_q.psr_immediate;
  assign cp_op            = dec_q.cp_op;
  assign cp_num           = dec_q.cp_num;
  assign cp_rd            = dec_q.cp_rd;
  assign cp_rn            = dec_q.cp_rn;
  assign cp_opcode1       = dec_q.cp_opcode1;
  assign cp_opcode2       = dec_q.cp_opcode2;
  assign cp_load          = dec_q.cp_load;
  assign thumb_instr_type = dec_q.thumb.ttype;
  assign thumb_rd         = dec_q.thumb.rd;
  assign thumb_rs         = dec_q.thumb.rs;
  assign thumb_rn         = dec_q.thumb.rn;
  assign thumb_imm8       = dec_q.thumb.imm8;
  assign thumb_imm5       = dec_q.thumb.imm5;
  assign thumb_offset11   = dec_q.thumb.offset11;
  assign thumb_offset8    = dec_q.thumb.offset8;
  assign pc_out           = dec_q.pc;
  assign decode_valid     = valid_q;

endmodule

// File: tb/tb_arm7tdmi_instr_decode.sv
// Scoreboard bench for the ARM7TDMI decode stage.
// Expected field values are queued at drive time, checked after the edge.
module tb_arm7tdmi_instr_decode;
  import arm7tdmi_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  instruction;
  logic [31:0]  pc_in;
  logic         instr_valid;
  logic         stall;
  logic         flush;
  logic         thumb_mode;
  condition_t   condition;
  instr_type_t  instr_type;
  alu_op_t      alu_op;
  logic [3:0]   rd, rn, rm;
  logic [11:0]  immediate;
  logic         imm_en, set_flags;
  logic [1:0]   shift_type;
  logic [4:0]   shift_amount;
  logic         shift_reg;
  logic [3:0]   shift_rs;
  logic         is_memory, mem_load, mem_byte;
  logic         mem_pre, mem_up, mem_writeback;
  logic         is_branch;
  logic [23:0]  branch_offset;
  logic         branch_link;
  logic         psr_to_reg, psr_spsr, psr_immediate;
  logic         cp_op;
  logic [3:0]   cp_num, cp_rd, cp_rn, cp_opcode1;
  logic [2:0]   cp_opcode2;
  logic         cp_load;
  thumb_instr_t thumb_instr_type;
  logic [2:0]   thumb_rd, thumb_rs, thumb_rn;
  logic [7:0]   thumb_imm8;
  logic [4:0]   thumb_imm5;
  logic [10:0]  thumb_offset11;
  logic [7:0]   thumb_offset8;
  logic [31:0]  pc_out;
  logic         decode_valid;

  always #5 clk = ~clk;

  arm7tdmi_instr_decode dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction      (instruction),
    .pc_in            (pc_in),
    .instr_valid      (instr_valid),
    .stall            (stall),
    .flush            (flush),
    .thumb_mode       (thumb_mode),
    .condition        (condition),
    .instr_type       (instr_type),
    .alu_op           (alu_op),
    .rd               (rd),
    .rn               (rn),
    .rm               (rm),
    .immediate        (immediate),
    .imm_en           (imm_en),
    .set_flags        (set_flags),
    .shift_type       (shift_type),
    .shift_amount     (shift_amount),
    .shift_reg        (shift_reg),
    .shift_rs         (shift_rs),
    .is_memory        (is_memory),
    .mem_load         (mem_load),
    .mem_byte         (mem_byte),
    .mem_pre          (mem_pre),
    .mem_up           (mem_up),
    .mem_writeback    (mem_writeback),
    .is_branch        (is_branch),
    .branch_offset    (branch_offset),
    .branch_link      (branch_link),
    .psr_to_reg       (psr_to_reg),
    .psr_spsr         (psr_spsr),
    .psr_immediate    (psr_immediate),
    .cp_op            (cp_op),
    .cp_num           (cp_num),
    .cp_rd            (cp_rd),
    .cp_rn            (cp_rn),
    .cp_opcode1       (cp_opcode1),
    .cp_opcode2       (cp_opcode2),
    .cp_load          (cp_load),
    .thumb_instr_type (thumb_instr_type),
    .thumb_rd         (thumb_rd),
    .thumb_rs         (thumb_rs),
    .thumb_rn         (thumb_rn),
    .thumb_imm8       (thumb_imm8),
    .thumb_imm5       (thumb_imm5),
    .thumb_offset11   (thumb_offset11),
    .thumb_offset8    (thumb_offset8),
    .pc_out           (pc_out),
    .decode_valid     (decode_valid)
  );

  localparam int S_VALID = 0,  S_COND = 1,  S_TYPE = 2;
  localparam int S_ALU   = 3,  S_RD   = 4,  S_RN   = 5;
  localparam int S_RM    = 6,  S_IMM  = 7,  S_IMEN = 8;
  localparam int S_SETF  = 9,  S_SHT  = 10, S_SHRG = 11;
  localparam int S_SHRS  = 12, S_MEM  = 13, S_LOAD = 14;
  localparam int S_BYTE  = 15, S_PRE  = 16, S_UP   = 17;
  localparam int S_WB    = 18, S_BR   = 19, S_BOFF = 20;
  localparam int S_BL    = 21, S_PREG = 22, S_SPSR = 23;
  localparam int S_TTYP  = 24, S_TRD  = 25, S_TRS  = 26;
  localparam int S_TRN   = 27, S_TI8  = 28, S_TO11 = 29;
  localparam int S_PC    = 30, S_CP   = 31;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_VALID: return 32'(decode_valid);
      S_COND:  return 32'(condition);
      S_TYPE:  return 32'(instr_type);
      S_ALU:   return 32'(alu_op);
      S_RD:    return 32'(rd);
      S_RN:    return 32'(rn);
      S_RM:    return 32'(rm);
      S_IMM:   return 32'(immediate);
      S_IMEN:  return 32'(imm_en);
      S_SETF:  return 32'(set_flags);
      S_SHT:   return 32'(shift_type);
      S_SHRG:  return 32'(shift_reg);
      S_SHRS:  return 32'(shift_rs);
      S_MEM:   return 32'(is_memory);
      S_LOAD:  return 32'(mem_load);
      S_BYTE:  return 32'(mem_byte);
      S_PRE:   return 32'(mem_pre);
      S_UP:    return 32'(mem_up);
      S_WB:    return 32'(mem_writeback);
      S_BR:    return 32'(is_branch);
      S_BOFF:  return 32'(branch_offset);
      S_BL:    return 32'(branch_link);
      S_PREG:  return 32'(psr_to_reg);
      S_SPSR:  return 32'(psr_spsr);
      S_TTYP:  return 32'(thumb_instr_type);
      S_TRD:   return 32'(thumb_rd);
      S_TRS:   return 32'(thumb_rs);
      S_TRN:   return 32'(thumb_rn);
      S_TI8:   return 32'(thumb_imm8);
      S_TO11:  return 32'(thumb_offset11);
      S_PC:    return pc_out;
      S_CP:    return 32'(cp_op);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [31:0] got,
                          logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic push_exp(string tag, int sel, logic [31:0] v);
    sb.push_back('{tag, sel, v});
  endtask

  task automatic drain();
    sb_item_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic step(logic [31:0] ins, logic [31:0] pc,
                      logic vld, logic thm, logic stl, logic fls);
    instruction = ins;
    pc_in       = pc;
    instr_valid = vld;
    thumb_mode  = thm;
    stall       = stl;
    flush       = fls;
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    instruction = 32'hE3A0_0005;
    pc_in = 32'h1234;
    instr_valid = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    thumb_mode = 1'b0;
    #12;
    push_exp("rst_valid", S_VALID, 0);
    push_exp("rst_cond", S_COND, 32'(COND_EQ));
    push_exp("rst_type", S_TYPE, 0);
    push_exp("rst_rd", S_RD, 0);
    push_exp("rst_imm", S_IMM, 0);
    push_exp("rst_pc", S_PC, 0);
    drain();
    rst_n = 1'b1;

    push_exp("swp_type", S_TYPE, 32'(INSTR_SINGLE_SWAP));
    push_exp("swp_rn", S_RN, 0);
    push_exp("swp_rd", S_RD, 0);
    push_exp("swp_rm", S_RM, 1);
    push_exp("swp_byte", S_BYTE, 0);
    push_exp("swp_mem", S_MEM, 1);
    push_exp("swp_load", S_LOAD, 1);
    push_exp("swp_pre", S_PRE, 1);
    push_exp("swp_up", S_UP, 1);
    push_exp("swp_wb", S_WB, 0);
    push_exp("swp_valid", S_VALID, 1);
    push_exp("swp_cond", S_COND, 32'(COND_AL));
    push_exp("swp_pc", S_PC, 32'h100);
    step(32'hE100_0091, 32'h100, 1, 0, 0, 0);

    push_exp("swpb_rn", S_RN, 3);
    push_exp("swpb_rd", S_RD, 2);
    push_exp("swpb_rm", S_RM, 4);
    push_exp("swpb_byte", S_BYTE, 1);
    step(32'hE143_2094, 32'h104, 1, 0, 0, 0);

    push_exp("swp2_rn", S_RN, 5);
    push_exp("swp2_rd", S_RD, 6);
    push_exp("swp2_rm", S_RM, 5);
    step(32'hE145_6095, 32'h108, 1, 0, 0, 0);

    push_exp("mov_type", S_TYPE, 32'(INSTR_DATA_PROC));
    push_exp("mov_alu", S_ALU, 32'(ALU_MOV));
    push_exp("mov_imen", S_IMEN, 1);
    push_exp("mov_imm", S_IMM, 5);
    push_exp("mov_rd", S_RD, 0);
    push_exp("mov_mem", S_MEM, 0);
    push_exp("mov_byte", S_BYTE, 0);
    step(32'hE3A0_0005, 32'h10C, 1, 0, 0, 0);

    push_exp("bl_type", S_TYPE, 32'(INSTR_BRANCH));
    push_exp("bl_br", S_BR, 1);
    push_exp("bl_link", S_BL, 1);
    push_exp("bl_off", S_BOFF, 32'h10);
    push_exp("bl_imm", S_IMM, 0);
    step(32'hEB00_0010, 32'h110, 1, 0, 0, 0);

    push_exp("ldr_type", S_TYPE, 32'(INSTR_SINGLE_XFER));
    push_exp("ldr_load", S_LOAD, 1);
    push_exp("ldr_pre", S_PRE, 1);
    push_exp("ldr_up", S_UP, 1);
    push_exp("ldr_wb", S_WB, 0);
    push_exp("ldr_imm", S_IMM, 4);
    push_exp("ldr_rn", S_RN, 1);
    push_exp("ldr_br", S_BR, 0);
    step(32'hE591_0004, 32'h114, 1, 0, 0, 0);

    push_exp("bx_type", S_TYPE, 32'(INSTR_BX));
    push_exp("bx_rm", S_RM, 3);
    push_exp("bx_br", S_BR, 1);
    step(32'hE12F_FF13, 32'h118, 1, 0, 0, 0);

    push_exp("mrs_type", S_TYPE, 32'(INSTR_PSR));
    push_exp("mrs_toreg", S_PREG, 1);
    push_exp("mrs_spsr", S_SPSR, 1);
    push_exp("mrs_rd", S_RD, 1);
    step(32'hE14F_1000, 32'h11C, 1, 0, 0, 0);

    push_exp("swi_type", S_TYPE, 32'(INSTR_SWI));
    push_exp("swi_cp", S_CP, 0);
    step(32'hEF00_0000, 32'h120, 1, 0, 0, 0);

    push_exp("inv_valid", S_VALID, 0);
    push_exp("inv_cond", S_COND, 32'(COND_EQ));
    push_exp("inv_type", S_TYPE, 32'(INSTR_DATA_PROC));
    push_exp("inv_alu", S_ALU, 32'(ALU_AND));
    push_exp("inv_setf", S_SETF, 1);
    push_exp("inv_rn", S_RN, 2);
    push_exp("inv_rd", S_RD, 3);
    push_exp("inv_rm", S_RM, 6);
    push_exp("inv_sht", S_SHT, 32'(SHIFT_ASR));
    push_exp("inv_shrg", S_SHRG, 1);
    push_exp("inv_shrs", S_SHRS, 4);
    push_exp("inv_imen", S_IMEN, 0);
    step(32'h0012_3456, 32'h124, 0, 0, 0, 0);

    push_exp("add_alu", S_ALU, 32'(ALU_ADD));
    push_exp("add_rd", S_RD, 2);
    push_exp("add_valid", S_VALID, 1);
    step(32'hE081_2003, 32'h200, 1, 0, 0, 0);

    for (int i = 0; i < 2; i++) begin
      push_exp("stl_valid", S_VALID, 1);
      push_exp("stl_type", S_TYPE, 32'(INSTR_DATA_PROC));
      push_exp("stl_alu", S_ALU, 32'(ALU_ADD));
      push_exp("stl_rd", S_RD, 2);
      push_exp("stl_rn", S_RN, 1);
      push_exp("stl_rm", S_RM, 3);
      push_exp("stl_pc", S_PC, 32'h200);
      step(i == 0 ? 32'hEB00_0010 : 32'hE591_0004,
           32'h300 + 32'(i), 1, 0, 1, 0);
    end

    push_exp("fl_valid", S_VALID, 0);
    push_exp("fl_rd", S_RD, 2);
    push_exp("fl_alu", S_ALU, 32'(ALU_ADD));
    push_exp("fl_pc", S_PC, 32'h200);
    step(32'hE3A0_0005, 32'h400, 1, 0, 1, 1);

    push_exp("t_mov_type", S_TYPE, 32'(INSTR_THUMB));
    push_exp("t_mov_fmt", S_TTYP, 32'(THUMB_MOV_CMP_IMM));
    push_exp("t_mov_rd", S_TRD, 0);
    push_exp("t_mov_imm8", S_TI8, 5);
    push_exp("t_mov_cond", S_COND, 32'(COND_AL));
    push_exp("t_mov_alu", S_ALU, 0);
    push_exp("t_mov_armimm", S_IMM, 0);
    push_exp("t_mov_valid", S_VALID, 1);
    step(32'h0000_2005, 32'h500, 1, 1, 0, 0);

    push_exp("t_add_fmt", S_TTYP, 32'(THUMB_ADD_SUB));
    push_exp("t_add_rd", S_TRD, 0);
    push_exp("t_add_rs", S_TRS, 1);
    push_exp("t_add_rn", S_TRN, 2);
    push_exp("t_add_imm8", S_TI8, 0);
    step(32'h0000_1888, 32'h502, 1, 1, 0, 0);

    push_exp("t_b_fmt", S_TTYP, 32'(THUMB_UNCOND_BR));
    push_exp("t_b_off", S_TO11, 32'h7FE);
    push_exp("t_b_armbr", S_BR, 0);
    step(32'h0000_E7FE, 32'h504, 1, 1, 0, 0);

    #3;
    rst_n = 1'b0;
    #1;
    push_exp("mrst_valid", S_VALID, 0);
    push_exp("mrst_cond", S_COND, 32'(COND_EQ));
    push_exp("mrst_type", S_TYPE, 0);
    push_exp("mrst_ttyp", S_TTYP, 0);
    push_exp("mrst_to11", S_TO11, 0);
    push_exp("mrst_pc", S_PC, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_instr_decode.md
# arm7tdmi_instr_decode

Decode stage of the ARM7TDMI pipeline. Takes the fetched 32-bit ARM word (or 16-bit Thumb halfword in `instruction[15:0]`) plus its PC, classifies it, and extracts all operand fields into a registered bundle for execute. It is purely a field decoder: it performs no register reads and no condition evaluation.

## Interface
- No parameters. Types come from `arm7tdmi_pkg`.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset; asynchronous, active-low.
- `instruction` input 32: fetched word.
- `pc_in` input 32: PC of the word.
- `instr_valid` input 1: word is valid.
- `stall` input 1: hold outputs.
- `flush` input 1: kill the stage.
- `thumb_mode` input 1: decode as Thumb.
- `condition` output `condition_t`: `[31:28]`.
- `instr_type` output `instr_type_t`: class.
- `alu_op` output `alu_op_t`: `[24:21]`.
- `rd`, `rn`, `rm` outputs 4 each: `[15:12]`, `[19:16]`, `[3:0]`.
- `immediate` output 12: `[11:0]`.
- `imm_en` output 1: I bit.
- `set_flags` output 1: S bit.
- `shift_type` output 2, `shift_amount` output 5, `shift_reg` output 1, `shift_rs` output 4: shifter operand fields.
- `is_memory` output 1, `mem_load` output 1, `mem_byte` output 1, `mem_pre` output 1, `mem_up` output 1, `mem_writeback` output 1: memory access controls.
- `is_branch` output 1, `branch_offset` output 24, `branch_link` output 1: branch controls.
- `psr_to_reg` output 1 (MRS), `psr_spsr` output 1, `psr_immediate` output 1: PSR transfer controls.
- `cp_op` output 1, `cp_num` output 4, `cp_rd` output 4, `cp_rn` output 4, `cp_opcode1` output 4, `cp_opcode2` output 3, `cp_load` output 1: coprocessor fields.
- `thumb_instr_type` output `thumb_instr_t`; `thumb_rd`, `thumb_rs`, `thumb_rn` outputs 3 each; `thumb_imm8` output 8; `thumb_imm5` output 5; `thumb_offset11` output 11; `thumb_offset8` output 8: Thumb fields.
- `pc_out` output 32: registered `pc_in`.
- `decode_valid` output 1: outputs are meaningful.

## Operation
- ARM classification, first match wins, on bits `[27:4]`:
  - BX: `0x12FFF1`.
  - Single swap: `00010B00`, `[11:4]=00001001`.
  - Multiply / long multiply: `000000xx` or `00001xxx`, `[7:4]=1001`.
  - Halfword transfer: `000`, `[7]=1`, `[4]=1`.
  - PSR transfer: `00x10xx0`, S=0.
  - Data processing: `00`.
  - Undefined: `011`, `[4]=1`.
  - Single transfer: `01`.
  - Block transfer: `100`.
  - Branch: `101`.
  - Coprocessor data transfer: `110`.
  - Coprocessor op / register transfer: `1110`, split on `[4]`.
  - SWI: `1111`.
- Swap (`INSTR_SINGLE_SWAP`):
  - `is_memory=1`, `mem_load=1`, `mem_pre=1`, `mem_up=1`, `mem_writeback=0`.
  - `mem_byte=[22]`.
  - `rn`=base, `rd`=destination, `rm`=source.
- Single, halfword and block transfers drive `mem_pre`, `mem_up`, `mem_byte`, `mem_writeback`, `mem_load` from bits P, U, B, W, L (`[24:20]`).
- Branch: `branch_offset=[23:0]` (raw; execute sign-extends and shifts), `branch_link=[24]`.
- Fields not meaningful for the decoded class are driven to 0. `condition` is always `[31:28]`.
- Thumb mode:
  - ARM control outputs are zero; `instr_type=INSTR_THUMB`.
  - `thumb_instr_type` selects the 19 Thumb formats from `instruction[15:8]`.
  - Thumb fields are extracted from their format positions; unused fields are 0.
  - `condition=AL`.

## Timing
- All outputs are registered: one cycle latency from inputs to outputs.
- Reset: every output is 0, `condition=EQ` (0), `decode_valid=0`.
- Priority on each `posedge clk`: `flush` over `stall` over load.
  - `flush`: `decode_valid<=0`; other outputs hold.
  - `stall`: all outputs hold.
  - Otherwise: all fields load and `decode_valid<=instr_valid`.
- `instr_valid=0` still loads the fields but clears `decode_valid`.
- Reset asserted mid-stream forces reset values immediately.

## Structure
- `arm7tdmi_pkg` holds `condition_t`, `instr_type_t` (including `INSTR_SINGLE_SWAP`, `INSTR_THUMB`), `alu_op_t`, `shift_type_t`, `thumb_instr_t`.
- One combinational sub-module, `arm7tdmi_thumb_field_decode`, is natural. The rest is a single combinational decode block feeding one output register bank.

## Test plan
- `0xE1000091` -> `INSTR_SINGLE_SWAP`, `rn=0`, `rd=0`, `rm=1`, `mem_byte=0`, `is_memory=1`, `mem_load=1`, `decode_valid=1` after one clock.
- `0xE1432094` (SWPB) -> `rn=3`, `rd=2`, `rm=4`, `mem_byte=1`. `0xE1456095` -> `rn=5`, `rd=6`, `rm=5`.
- `0xE3A00005` -> data processing, `alu_op=MOV`, `imm_en=1`, `immediate=0x005`, `rd=0`, `is_memory=0`.
- `0xEB000010` -> branch, `is_branch=1`, `branch_link=1`, `branch_offset=0x000010`. `0xE5910004` -> single transfer, `mem_load=1`, `mem_pre=1`, `mem_up=1`, `immediate=0x004`.
- Stall held two cycles while the instruction changes -> outputs unchanged. Then `flush` -> `decode_valid=0`. Reset mid-operation -> all outputs 0.
- `thumb_mode=1`, `0x2005` (MOV R0,#5) -> `thumb_rd=0`, `thumb_imm8=0x05`, `condition=AL`.
